jpeg_seg_carry_adder: RTL

Parametrised, pipelined segmented-carry adder/subtractor for the JPEG datapath. It generalises the single-bit carry/compare chain used in the DCT/quantiser paths into a WIDTH-bit operation. The carry ripples through SEGS register-separated segments, giving a fixed latency of SEGS cycles. Sits between coefficient accumulation and quantisation, with a valid/ready handshake on both sides.

---
 rtl/jpeg_seg_carry_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jpeg_seg_carry_adder.sv
// Segmented-carry adder/subtractor: each of SEGS register stages adds one SEG_W slice, carry ripples stage to stage.
// Latency SEGS cycles, one result per cycle; a global stall (out_valid & ~out_ready) freezes every stage.
// Define JPEG_SAT_EN to saturate add overflow to all-ones and clamp subtract borrow to zero in the last stage.
module jpeg_seg_carry_adder #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_flag
);
    localparam int SEG_W = WIDTH / SEGS;
    localparam int LAST  = SEGS - 1;

    // Stage registers for stages 0..LAST-1; the last stage registers into the r_out_* set.
    logic             r_vld [SEGS];
    logic [WIDTH-1:0] r_a   [SEGS];
    logic [WIDTH-1:0] r_b   [SEGS];
    logic [WIDTH-1:0] r_sum [SEGS];
    logic             r_c   [SEGS];
    logic             r_sub [SEGS];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_zero;
    logic             r_out_flag;

    logic             w_vld_in  [SEGS];
    logic [WIDTH-1:0] w_a_in    [SEGS];
    logic [WIDTH-1:0] w_b_in    [SEGS];
    logic [WIDTH-1:0] w_sum_in  [SEGS];
    logic             w_c_in    [SEGS];
    logic             w_sub_in  [SEGS];
    logic [SEG_W:0]   w_seg     [SEGS];
    logic [WIDTH-1:0] w_sum_nxt [SEGS];

    logic             w_stall;
    logic             w_cout;
    logic             w_sub_last;
    logic [WIDTH-1:0] w_fin_sum;

    assign w_stall  = r_out_vld & ~out_ready;
    assign in_ready = ~w_stall;

    always_comb begin
        // Subtract enters as A + ~B + 1; the inverted B travels down the pipe with A.
        w_vld_in[0] = in_valid;
        w_a_in[0]   = in_a;
        w_b_in[0]   = in_sub ? ~in_b : in_b;
        w_sum_in[0] = '0;
        w_c_in[0]   = in_sub | in_cin;
        w_sub_in[0] = in_sub;
        for (int k = 1; k < SEGS; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_sum_in[k] = r_sum[k-1];
            w_c_in[k]   = r_c[k-1];
            w_sub_in[k] = r_sub[k-1];
        end
        for (int k = 0; k < SEGS; k++) begin
            w_seg[k] = {1'b0, w_a_in[k][k*SEG_W +: SEG_W]}
                     + {1'b0, w_b_in[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, w_c_in[k]};
            w_sum_nxt[k] = w_sum_in[k];
            w_sum_nxt[k][k*SEG_W +: SEG_W] = w_seg[k][SEG_W-1:0];
        end
    end

    assign w_cout     = w_seg[LAST][SEG_W];
    assign w_sub_last = w_sub_in[LAST];

    always_comb begin
        w_fin_sum = w_sum_nxt[LAST];
`ifdef JPEG_SAT_EN
        if (!w_sub_last && w_cout) begin
            w_fin_sum = '1;
        end else if (w_sub_last && !w_cout) begin
            w_fin_sum = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SEGS; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_sub[k] <= 1'b0;
            end
            r_out_vld  <= 1'b0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_out_zero <= 1'b0;
            r_out_flag <= 1'b0;
        end else if (!w_stall) begin
            // Bubbles advance too, so valid bits shift every unstalled cycle.
            for (int k = 0; k < LAST; k++) begin
                r_vld[k] <= w_vld_in[k];
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_sum[k] <= w_sum_nxt[k];
                r_c[k]   <= w_seg[k][SEG_W];
                r_sub[k] <= w_sub_in[k];
            end
            r_out_vld  <= w_vld_in[LAST];
            r_out_sum  <= w_fin_sum;
            r_out_cout <= w_cout;
            r_out_zero <= (w_fin_sum == '0);
            r_out_flag <= ~(w_cout ^ w_sub_last);
        end
    end

    assign out_valid = r_out_vld;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_zero  = r_out_zero;
    assign out_flag  = r_out_flag;

endmodule
